// File: rtl/nd_int_pkg.sv
// Shared NORD-10/S interrupt definitions:
// responder state encoding, level base and widths.
package nd_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int LVL_BASE = 10;
  localparam int CODE_W   = 9;
  localparam int BUS_W    = 16;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/ident_chain_gate.sv
// Daisy-chain gate: PRI_OUT pass/block and IDENT claim decode.
// pri_in/out chain, ident_req/lvl strobe, pend/ack state in, claim out.
module ident_chain_gate #(
  parameter logic [1:0] LVL_IDX = 2'd3
) (
  input  logic       pri_in,
  input  logic       ident_req,
  input  logic [1:0] ident_lvl,
  input  logic       pend,
  input  logic       ack,
  output logic       pri_out,
  output logic       claim
);

  logic lvl_hit;

  assign lvl_hit = (ident_lvl == LVL_IDX);

  // Blocked while pending on the identified level or acking.
  assign pri_out = pri_in & ~(pend & lvl_hit) & ~ack;

  assign claim = ident_req & lvl_hit & pri_in & pend;

endmodule

// File: rtl/ident_resp.sv
// Interrupt requester / IDENT responder for levels 10-13.
// Ports: clk, MCL (async reset), INT_SET/CLR, IDENT_REQ/LVL,
//   PRI_IN/OUT chain, IREQ[3:0], IDENT_ACK, IB_ut[15:0].
module ident_resp
  import nd_int_pkg::*;
#(
  parameter int         LEVEL      = 13,
  parameter logic [8:0] IDENT_CODE = 9'o001,
  parameter int         HOLD       = 2
) (
  input  logic        clk,
  input  logic        MCL,
  input  logic        INT_SET,
  input  logic        INT_CLR,
  input  logic        IDENT_REQ,
  input  logic [1:0]  IDENT_LVL,
  input  logic        PRI_IN,
  output logic        PRI_OUT,
  output logic [3:0]  IREQ,
  output logic        IDENT_ACK,
  output logic [15:0] IB_ut
);

  if (LEVEL < 10 || LEVEL > 13) begin : g_bad_level
    $error("ident_resp: LEVEL must be 10..13");
  end
  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("ident_resp: HOLD must be 1..15");
  end

  localparam logic [1:0] LVL_IDX = 2'(LEVEL - LVL_BASE);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rearm_q, rearm_d;
  logic [3:0]       ireq_q, ireq_d;
  logic             ack_q, ack_d;
  logic [BUS_W-1:0] ib_q, ib_d;

  logic claim;
  logic rearm_nx;

  ident_chain_gate #(
    .LVL_IDX(LVL_IDX)
  ) u_gate (
    .pri_in   (PRI_IN),
    .ident_req(IDENT_REQ),
    .ident_lvl(IDENT_LVL),
    .pend     (state_q == ST_PEND),
    .ack      (state_q == ST_ACK),
    .pri_out  (PRI_OUT),
    .claim    (claim)
  );

  // Clear beats set when both land in one ack cycle.
  assign rearm_nx = (rearm_q | INT_SET) & ~INT_CLR;

  always_ff @(posedge clk or posedge MCL) begin
    if (MCL) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rearm_q <= 1'b0;
      ireq_q  <= '0;
      ack_q   <= 1'b0;
      ib_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
      ireq_q  <= ireq_d;
      ack_q   <= ack_d;
      ib_q    <= ib_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    unique case (state_q)
      ST_IDLE: begin
        if (INT_SET && !INT_CLR) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (claim) begin
          state_d = ST_ACK;
          cnt_d   = HOLD_M1;
          rearm_d = 1'b0;
        end else if (INT_CLR) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        // A set in the last ack cycle still rearms.
        if (cnt_q == '0) begin
          state_d = rearm_nx ? ST_PEND : ST_IDLE;
          rearm_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          rearm_d = rearm_nx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs registered off the next state.
  always_comb begin
    ireq_d = '0;
    ack_d  = 1'b0;
    ib_d   = '0;
    unique case (1'b1)
      (state_d == ST_PEND): ireq_d = 4'b0001 << LVL_IDX;
      (state_d == ST_ACK): begin
        ack_d = 1'b1;
        ib_d  = {{(BUS_W - CODE_W){1'b0}}, IDENT_CODE};
      end
      default: ;
    endcase
  end

  assign IREQ      = ireq_q;
  assign IDENT_ACK = ack_q;
  assign IB_ut     = ib_q;

endmodule
